// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and types for the instruction load memory.
package cpu_pkg;
  localparam logic [31:0] CPU_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    LDM_IDLE = 2'd0,
    LDM_LOAD = 2'd1,
    LDM_RUN  = 2'd2
  } ldmem_state_t;
endpackage

// File: rtl/instr_load_mem_if.sv
// Load/fetch bus between the CPU front end and the instruction memory.
interface instr_load_mem_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int PC_W   = 32,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              LoadInstructions;
  logic [DATA_W-1:0] Instruction;
  logic [PC_W-1:0]   fetch_addr;
  logic [DATA_W-1:0] fetch_instr;
  logic              prog_done;
  logic              running;
  logic              loading;
  logic [ADDR_W:0]   prog_len;
  logic              load_overflow;

  modport master (
    output LoadInstructions, Instruction, fetch_addr,
    input  fetch_instr, prog_done, running, loading, prog_len, load_overflow
  );

  modport slave (
    input  LoadInstructions, Instruction, fetch_addr,
    output fetch_instr, prog_done, running, loading, prog_len, load_overflow
  );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A same-address read/write returns the word stored before the edge.
module sdp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/instr_load_mem.sv
// Instruction memory: serial program load from address 0, then qualified
// registered fetch returning NOP_WORD and prog_done beyond the program end.
module instr_load_mem
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(CPU_NOP_WORD)
) (
  input logic              clk,
  input logic              Reset,
  instr_load_mem_if.slave  bus
);
  localparam logic [1:0]    S_IDLE  = LDM_IDLE;
  localparam logic [1:0]    S_LOAD  = LDM_LOAD;
  localparam logic [1:0]    S_RUN   = LDM_RUN;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam int            CMP_W   = (PC_W > ADDR_W + 1) ? PC_W : ADDR_W + 1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              ovf_q, ovf_d;
  logic              fvalid_q, fvalid_d;
  logic              done_q, done_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] rd_data;
  logic [CMP_W-1:0]  addr_ext, len_ext;
  logic              in_range;

  // Full-width compare so PCs at or past DEPTH never alias into the RAM.
  assign addr_ext = CMP_W'(bus.fetch_addr);
  assign len_ext  = CMP_W'(prog_len_q);
  assign in_range = addr_ext < len_ext;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    waddr      = wr_ptr_q[ADDR_W-1:0];

    case (state_q)
      S_LOAD: begin
        if (bus.LoadInstructions) begin
          if (wr_ptr_q < DEPTH_L) begin
            we         = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prog_len_d = wr_ptr_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // IDLE and RUN both start a fresh program on a load strobe.
        if (bus.LoadInstructions) begin
          state_d    = S_LOAD;
          we         = 1'b1;
          waddr      = '0;
          wr_ptr_d   = (ADDR_W+1)'(1);
          prog_len_d = (ADDR_W+1)'(1);
          ovf_d      = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
    endcase

    // prog_len survives reset so a loaded program can be run after it.
    if (Reset) begin
      we         = 1'b0;
      prog_len_d = prog_len_q;
    end
  end

  always_comb begin
    fvalid_d = (state_q == S_RUN) && in_range;
    done_d   = (state_q == S_RUN) && !in_range;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      fvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
      fvalid_q <= fvalid_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    prog_len_q <= prog_len_d;
  end

  sdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (we),
    .wr_addr(waddr),
    .wr_data(bus.Instruction),
    .rd_addr(bus.fetch_addr[ADDR_W-1:0]),
    .rd_data(rd_data)
  );

  assign bus.fetch_instr   = fvalid_q ? rd_data : NOP_WORD;
  assign bus.prog_done     = done_q;
  assign bus.running       = (state_q == S_RUN);
  assign bus.loading       = (state_q == S_LOAD);
  assign bus.prog_len      = prog_len_q;
  assign bus.load_overflow = ovf_q;
endmodule

// File: tb/tb_instr_load_mem.sv
// Drives a DEPTH=64 and a DEPTH=8 memory with identical stimulus and checks
// both against a cycle-level program-memory model every clock.
module tb_instr_load_mem;
  localparam int          DW  = 32;
  localparam int          PW  = 32;
  localparam int          DA  = 64;
  localparam int          DB  = 8;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        Reset;
  logic        ld;
  logic [31:0] instr;
  logic [31:0] fa;

  int checks = 0;
  int errors = 0;

  instr_load_mem_if #(.DATA_W(DW), .DEPTH(DA), .PC_W(PW)) bus_a ();
  instr_load_mem_if #(.DATA_W(DW), .DEPTH(DB), .PC_W(PW)) bus_b ();

  assign bus_a.LoadInstructions = ld;
  assign bus_a.Instruction      = instr;
  assign bus_a.fetch_addr       = fa;
  assign bus_b.LoadInstructions = ld;
  assign bus_b.Instruction      = instr;
  assign bus_b.fetch_addr       = fa;

  instr_load_mem #(.DATA_W(DW), .DEPTH(DA), .PC_W(PW), .NOP_WORD(NOP)) dut_a (
    .clk(clk), .Reset(Reset), .bus(bus_a));
  instr_load_mem #(.DATA_W(DW), .DEPTH(DB), .PC_W(PW), .NOP_WORD(NOP)) dut_b (
    .clk(clk), .Reset(Reset), .bus(bus_b));

  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=load 2=run; index 0 -> dut_a, 1 -> dut_b.
  int          depth_m [2] = '{DA, DB};
  logic [31:0] mem_m   [2][64];
  int          mode_m  [2];
  int          cnt_m   [2];
  int          plen_m  [2];
  bit          plen_ok [2] = '{1'b0, 1'b0};
  bit          ov_m    [2];
  logic [31:0] fi_m    [2];
  bit          pd_m    [2];

  task automatic model_edge(input bit r, input bit l, input logic [31:0] w,
                            input logic [31:0] a);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mode_m[k] = 0; cnt_m[k] = 0; fi_m[k] = NOP; pd_m[k] = 1'b0; ov_m[k] = 1'b0;
      end else begin
        if (mode_m[k] == 2 && a < 32'(plen_m[k])) begin
          fi_m[k] = mem_m[k][a]; pd_m[k] = 1'b0;
        end else begin
          fi_m[k] = NOP; pd_m[k] = (mode_m[k] == 2);
        end
        if (mode_m[k] == 1) begin
          if (!l) mode_m[k] = 0;
          else if (cnt_m[k] < depth_m[k]) begin
            mem_m[k][cnt_m[k]] = w; cnt_m[k]++; plen_m[k] = cnt_m[k];
          end else ov_m[k] = 1'b1;
        end else if (l) begin
          mode_m[k] = 1; mem_m[k][0] = w; cnt_m[k] = 1; plen_m[k] = 1;
          plen_ok[k] = 1'b1; ov_m[k] = 1'b0;
        end else mode_m[k] = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.fetch_instr", 64'(bus_a.fetch_instr), 64'(fi_m[0]));
    chk("a.prog_done",   64'(bus_a.prog_done),   64'(pd_m[0]));
    chk("a.running",     64'(bus_a.running),     64'(mode_m[0] == 2));
    chk("a.loading",     64'(bus_a.loading),     64'(mode_m[0] == 1));
    chk("a.overflow",    64'(bus_a.load_overflow), 64'(ov_m[0]));
    if (plen_ok[0]) chk("a.prog_len", 64'(bus_a.prog_len), 64'(plen_m[0]));
    chk("b.fetch_instr", 64'(bus_b.fetch_instr), 64'(fi_m[1]));
    chk("b.prog_done",   64'(bus_b.prog_done),   64'(pd_m[1]));
    chk("b.running",     64'(bus_b.running),     64'(mode_m[1] == 2));
    chk("b.loading",     64'(bus_b.loading),     64'(mode_m[1] == 1));
    chk("b.overflow",    64'(bus_b.load_overflow), 64'(ov_m[1]));
    if (plen_ok[1]) chk("b.prog_len", 64'(bus_b.prog_len), 64'(plen_m[1]));
  endtask

  task automatic step(input bit r, input bit l, input logic [31:0] w, input logic [31:0] a);
    Reset = r; ld = l; instr = w; fa = a;
    @(posedge clk);
    model_edge(r, l, w, a);
    #1;
    check_all();
  endtask

  logic [31:0] prog [13];
  logic [31:0] old3;
  bit          ld_r;

  initial begin
    Reset = 1'b1; ld = 1'b0; instr = '0; fa = '0;

    // Reset state, then load 13 words (DEPTH=8 instance overflows).
    step(1, 0, 0, 0);
    chk("rst.fetch_nop", 64'(bus_a.fetch_instr), 64'(NOP));
    for (int i = 0; i < 13; i++) begin
      prog[i] = $urandom;
      step(0, 1, prog[i], 0);
    end
    step(0, 0, 0, 0);
    chk("load13.len_a", 64'(bus_a.prog_len), 64'd13);
    chk("load13.ovf_a", 64'(bus_a.load_overflow), 64'd0);
    chk("ovf.len_b",    64'(bus_b.prog_len), 64'd8);
    chk("ovf.ovf_b",    64'(bus_b.load_overflow), 64'd1);

    // Reset keeps the program; one edge to RUN, then fetch it back.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0, 32'(i));
      chk("run.word_a", 64'(bus_a.fetch_instr), 64'(prog[i]));
      if (i < 8) chk("ovf.word_b", 64'(bus_b.fetch_instr), 64'(prog[i]));
      else       chk("ovf.done_b", 64'(bus_b.prog_done), 64'd1);
    end

    // End of program and PC far beyond DEPTH.
    step(0, 0, 0, 32'd13);
    chk("eop.done13", 64'(bus_a.prog_done), 64'd1);
    step(0, 0, 0, 32'hFFFF_FFFF);
    chk("eop.doneMax", 64'(bus_a.prog_done), 64'd1);
    chk("eop.nopMax",  64'(bus_a.fetch_instr), 64'(NOP));
    step(0, 0, 0, 32'd12);
    chk("eop.word12", 64'(bus_a.fetch_instr), 64'(prog[12]));

    // Reload 3 words from RUN while fetching address 3.
    old3 = prog[3];
    for (int i = 0; i < 3; i++) begin
      step(0, 1, $urandom, 32'd3);
      if (i > 0) begin
        chk("gate.nop",  64'(bus_a.fetch_instr), 64'(NOP));
        chk("gate.done", 64'(bus_a.prog_done), 64'd0);
      end
    end
    step(0, 0, 0, 32'd3);
    chk("reload.len", 64'(bus_a.prog_len), 64'd3);
    chk("reload.ovf_b", 64'(bus_b.load_overflow), 64'd0);
    step(1, 0, 0, 32'd3);
    step(0, 0, 0, 32'd3);
    step(0, 0, 0, 32'd3);
    chk("reload.nop3",  64'(bus_a.fetch_instr), 64'(NOP));
    chk("reload.done3", 64'(bus_a.prog_done), 64'd1);

    // Reset together with a load strobe writes nothing.
    step(1, 1, 32'hDEAD_BEEF, 0);
    chk("rstld.len", 64'(bus_a.prog_len), 64'd3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rstld.nowrite", 64'(bus_a.fetch_instr == 32'hDEAD_BEEF), 64'd0);

    // Reset after 5 of 10 load words keeps the partial program.
    for (int i = 0; i < 5; i++) step(0, 1, $urandom, 0);
    step(1, 1, $urandom, 0);
    step(1, 0, 0, 0);
    chk("midload.len", 64'(bus_a.prog_len), 64'd5);
    step(0, 0, 0, 32'd4);
    step(0, 0, 0, 32'd5);
    chk("midload.done5", 64'(bus_a.prog_done), 64'd1);

    // Random traffic against the model.
    ld_r = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) ld_r = ~ld_r;
      step(($urandom_range(0, 40) == 0), ld_r, $urandom,
           ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
